// File: rtl/mem_wb_stage.sv
// mem_wb_stage: EX/MEM register, word-addressed data memory, MEM/WB register
// and write-back mux feeding the register bank. Adds lw/sw support downstream
// of the ALU with a fixed two-edge latency from ex_* to wb_*.

module mem_wb_stage #(
    parameter int DEPTH_LOG2 = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_write_reg,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_to_reg,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] wb_write_data,
    output logic        mem_addr_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic                  r_em_valid;
    logic [31:0]           r_em_alu;
    logic [31:0]           r_em_store_data;
    logic [4:0]            r_em_write_reg;
    logic                  r_em_reg_write;
    logic                  r_em_mem_read;
    logic                  r_em_mem_write;
    logic                  r_em_mem_to_reg;

    logic                  r_wb_valid;
    logic                  r_wb_reg_write;
    logic [4:0]            r_wb_write_reg;
    logic [31:0]           r_wb_write_data;
    logic                  r_addr_err;

    logic [31:0]           r_mem [DEPTH];

    logic [DEPTH_LOG2-1:0] w_word;
    logic                  w_misaligned;
    logic                  w_is_load;
    logic                  w_do_store;
    logic [31:0]           w_load_data;
    logic                  w_wb_reg_write;
    logic [31:0]           w_wb_data;

    // EX/MEM register: a bubble is captured with all fields zeroed so that
    // nothing downstream has to re-qualify the payload with valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_em_valid      <= 1'b0;
            r_em_alu        <= '0;
            r_em_store_data <= '0;
            r_em_write_reg  <= '0;
            r_em_reg_write  <= 1'b0;
            r_em_mem_read   <= 1'b0;
            r_em_mem_write  <= 1'b0;
            r_em_mem_to_reg <= 1'b0;
        end else if (ex_valid) begin
            r_em_valid      <= 1'b1;
            r_em_alu        <= ex_alu_result;
            r_em_store_data <= ex_store_data;
            r_em_write_reg  <= ex_write_reg;
            r_em_reg_write  <= ex_reg_write;
            r_em_mem_read   <= ex_mem_read;
            r_em_mem_write  <= ex_mem_write;
            r_em_mem_to_reg <= ex_mem_to_reg;
        end else begin
            r_em_valid      <= 1'b0;
            r_em_alu        <= '0;
            r_em_store_data <= '0;
            r_em_write_reg  <= '0;
            r_em_reg_write  <= 1'b0;
            r_em_mem_read   <= 1'b0;
            r_em_mem_write  <= 1'b0;
            r_em_mem_to_reg <= 1'b0;
        end
    end

    // MEM stage decode. Upper address bits are dropped so accesses wrap
    // modulo the memory size. A slot with both read and write set is a store.
    assign w_word         = r_em_alu[DEPTH_LOG2+1:2];
    assign w_misaligned   = r_em_valid & (r_em_mem_read | r_em_mem_write)
                            & (r_em_alu[1:0] != 2'b00);
    assign w_is_load      = r_em_mem_read & ~r_em_mem_write;
    assign w_do_store     = r_em_valid & r_em_mem_write & ~w_misaligned & ~rst;
    assign w_load_data    = r_mem[w_word];
    assign w_wb_reg_write = r_em_valid & r_em_reg_write
                            & (r_em_write_reg != 5'd0)
                            & ~(w_misaligned & w_is_load);
    assign w_wb_data      = ~r_em_valid ? 32'd0 :
                            ((r_em_mem_to_reg & w_is_load) ? w_load_data : r_em_alu);

    // Data memory write port; contents survive reset, but a reset edge
    // suppresses the store sitting in EX/MEM.
    always_ff @(posedge clk) begin
        if (w_do_store) begin
            r_mem[w_word] <= r_em_store_data;
        end
    end

    // MEM/WB register plus the sticky misaligned-access flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb_valid      <= 1'b0;
            r_wb_reg_write  <= 1'b0;
            r_wb_write_reg  <= '0;
            r_wb_write_data <= '0;
            r_addr_err      <= 1'b0;
        end else begin
            r_wb_valid      <= r_em_valid;
            r_wb_reg_write  <= w_wb_reg_write;
            r_wb_write_reg  <= r_em_write_reg;
            r_wb_write_data <= w_wb_data;
            if (w_misaligned) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    assign wb_valid      = r_wb_valid;
    assign wb_reg_write  = r_wb_reg_write;
    assign wb_write_reg  = r_wb_write_reg;
    assign wb_write_data = r_wb_write_data;
    assign mem_addr_err  = r_addr_err;

endmodule
